// File: rtl/case_conv_arbiter.sv
// Two-channel burst arbiter feeding one shared ASCII lowercase->uppercase stage with a registered output.
// Optional per-channel case-change counters: define CASE_STATS_EN.
module case_conv_arbiter #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_id,
  output logic          m_last,
  input  logic          m_ready
`ifdef CASE_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  // The conversion rule is defined on ASCII bytes only.
  if (DW != 8 || CNT_W < 1) begin : g_param_check
    $error("case_conv_arbiter: DW must be 8 and CNT_W must be positive");
  end

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t        state, state_nxt;
  logic          rr_ptr, rr_ptr_nxt;
  logic          hold_free;
  logic          acc0, acc1, acc_any;
  logic [DW-1:0] acc_data, conv_data;
  logic          acc_last;
  logic          acc_lower;

  // The holding register may be refilled in the same cycle it drains.
  assign hold_free = !m_valid || m_ready;
  assign s0_ready  = (state == BUSY0) && hold_free;
  assign s1_ready  = (state == BUSY1) && hold_free;

  assign acc0    = s0_valid && s0_ready;
  assign acc1    = s1_valid && s1_ready;
  assign acc_any = acc0 || acc1;

  assign acc_data  = acc1 ? s1_data : s0_data;
  assign acc_last  = acc1 ? s1_last : s0_last;
  assign acc_lower = (acc_data >= 8'h61) && (acc_data <= 8'h7A);
  assign conv_data = acc_lower ? (acc_data & 8'hDF) : acc_data;

  // NOTE: every variable gets a default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (s0_valid && (!s1_valid || !rr_ptr)) state_nxt = BUSY0;
        else if (s1_valid)                       state_nxt = BUSY1;
      end
      BUSY0: begin
        if (acc0 && s0_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = 1'b1;
        end
      end
      BUSY1: begin
        if (acc1 && s1_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // NOTE: the holding register is control-visible, so its payload is reset too, not just m_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 1'b0;
      m_last  <= 1'b0;
    end else if (acc_any) begin
      m_valid <= 1'b1;
      m_data  <= conv_data;
      m_id    <= acc1;
      m_last  <= acc_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef CASE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (acc0 && acc_lower) cnt0 <= cnt0 + CNT_W'(1);
      if (acc1 && acc_lower) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_case_conv_arbiter.sv
// Self-checking bench for case_conv_arbiter: directed scenarios plus randomized traffic against a scoreboard model.
// Counter checks are active when CASE_STATS_EN is defined.
module tb_case_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] s_valid, s_last, s_ready;
  logic [7:0] s_data [2];
  logic       m_valid, m_id, m_last, m_ready;
  logic [7:0] m_data;
`ifdef CASE_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  case_conv_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s_valid[0]),
    .s0_data  (s_data[0]),
    .s0_last  (s_last[0]),
    .s0_ready (s_ready[0]),
    .s1_valid (s_valid[1]),
    .s1_data  (s_data[1]),
    .s1_last  (s_last[1]),
    .s1_ready (s_ready[1]),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_id     (m_id),
    .m_last   (m_last),
    .m_ready  (m_ready)
`ifdef CASE_STATS_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  int errors = 0;
  int checks = 0;
  int tick   = 0;
  int p_valid = 100;
  int p_ready = 100;
  int stall_cnt = 0;
  int cnt_model [2];

  logic [8:0] src_q [2][$];   // {last, byte} per source channel
  logic       mr_q [$];       // scripted m_ready values, random/p_ready when empty
  logic [9:0] out_log [$];    // {id, last, byte} of every sink transfer
  int         out_cyc [$];

  function automatic bit is_lower(input logic [7:0] b);
    return (b >= "a") && (b <= "z");
  endfunction

  function automatic logic [7:0] ref_conv(input logic [7:0] b);
    return is_lower(b) ? b - 8'd32 : b;
  endfunction

  task automatic drive_step(input logic [1:0] acc);
    for (int c = 0; c < 2; c++) begin
      if (acc[c]) begin
        void'(src_q[c].pop_front());
        s_valid[c] = 1'b0;
      end
      if (!s_valid[c] && src_q[c].size() > 0 && ($urandom_range(99) < p_valid)) begin
        s_valid[c] = 1'b1;
        {s_last[c], s_data[c]} = src_q[c][0];
      end
    end
    m_ready = (mr_q.size() > 0) ? mr_q.pop_front() : ($urandom_range(99) < p_ready);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_valid = 2'b00;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cnt_model[0] = 0;
    cnt_model[1] = 0;
  endtask

  // Runs queued source traffic to completion, checking every cycle against the model.
  task automatic run_traffic(input int budget);
    bit         pend = 1'b0, held = 1'b0, done = 1'b0, other_pend = 1'b0;
    logic [9:0] pend_w = '0, held_w = '0, cur;
    logic [1:0] acc;
    int         owner = -1, prev_ch = -1, n = 0;
    out_log.delete();
    out_cyc.delete();
    stall_cnt = 0;
    drive_step(2'b00);
    while (!done) begin
      @(negedge clk);
      tick++;
      n++;
      acc = s_valid & s_ready;
      cur = {m_id, m_last, m_data};
      checks++;
      if (s_ready == 2'b11) begin
        errors++;
        $display("FAIL both_ready: got s_ready=%b required at most one", s_ready);
      end
      if (pend) begin
        checks++;
        if (m_valid !== 1'b1 || cur !== pend_w) begin
          errors++;
          $display("FAIL latency1_out: got v=%b {id,last,data}=%h required v=1 %h", m_valid, cur, pend_w);
        end
      end else if (held) begin
        checks++;
        if (m_valid !== 1'b1 || cur !== held_w) begin
          errors++;
          $display("FAIL hold_stable: got v=%b %h required v=1 %h", m_valid, cur, held_w);
        end
      end else begin
        checks++;
        if (m_valid !== 1'b0) begin
          errors++;
          $display("FAIL drain_valid: got m_valid=%b required 0", m_valid);
        end
      end
      if (m_valid && !m_ready) begin
        stall_cnt++;
        checks++;
        if (s_ready !== 2'b00) begin
          errors++;
          $display("FAIL stall_ready: got s_ready=%b required 00", s_ready);
        end
      end
      if (owner >= 0) begin
        checks++;
        if (s_ready[1-owner] !== 1'b0) begin
          errors++;
          $display("FAIL ungranted_ready: got s%0d_ready=%b required 0", 1 - owner, s_ready[1-owner]);
        end
      end
`ifdef CASE_STATS_EN
      checks++;
      if (cnt0 !== 16'(cnt_model[0]) || cnt1 !== 16'(cnt_model[1])) begin
        errors++;
        $display("FAIL counters: got %0d/%0d required %0d/%0d", cnt0, cnt1,
                 16'(cnt_model[0]), 16'(cnt_model[1]));
      end
`endif
      if (m_valid && m_ready) begin
        out_log.push_back(cur);
        out_cyc.push_back(tick);
      end
      pend = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (acc[c]) begin
          if (owner < 0) begin
            if (prev_ch >= 0 && other_pend) begin
              checks++;
              if (c != 1 - prev_ch) begin
                errors++;
                $display("FAIL rr_grant: got ch%0d required ch%0d", c, 1 - prev_ch);
              end
            end
            owner = c;
          end else begin
            checks++;
            if (c != owner) begin
              errors++;
              $display("FAIL interleave: got ch%0d required ch%0d", c, owner);
            end
          end
          pend   = 1'b1;
          pend_w = {1'(c), s_last[c], ref_conv(s_data[c])};
          if (is_lower(s_data[c])) cnt_model[c]++;
          if (s_last[c]) begin
            owner      = -1;
            prev_ch    = c;
            other_pend = s_valid[1-c];
          end
        end
      end
      held   = m_valid && !m_ready;
      held_w = cur;
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && acc == 2'b00 && !m_valid) begin
        done = 1'b1;
      end else if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d cycles without draining, required completion", n);
        src_q[0].delete();
        src_q[1].delete();
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) drive_step(acc);
    end
    s_valid = 2'b00;
    m_ready = 1'b1;
    mr_q.delete();
  endtask

  task automatic test_reset();
    cnt_model[0] = 0;
    cnt_model[1] = 0;
    rst_n = 1'b0;
    s_valid = 2'b11;
    s_data[0] = 8'h61; s_last[0] = 1'b1;
    s_data[1] = 8'h62; s_last[1] = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_data, m_id, m_last, s_ready} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%b l=%b rdy=%b required all 0",
               m_valid, m_data, m_id, m_last, s_ready);
    end
`ifdef CASE_STATS_EN
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", cnt0, cnt1);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: got s_ready=%b required 01", s_ready);
    end
    s_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid, m_id, m_last, m_data} !== {1'b1, 1'b0, 1'b1, 8'h41}) begin
      errors++;
      $display("FAIL reset_first_byte: got v=%b id=%b l=%b d=%h required 1 0 1 41",
               m_valid, m_id, m_last, m_data);
    end
    cnt_model[0] = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_b [4] = '{8'h41, 8'h42, 8'h5A, 8'h7B};
    src_q[0] = '{{1'b0, 8'h61}, {1'b0, 8'h62}, {1'b0, 8'h5A}, {1'b1, 8'h7B}};
    p_valid = 100; p_ready = 100;
    run_traffic(50);
    checks++;
    if (out_log.size() != 4) begin
      errors++;
      $display("FAIL burst_len: got %0d bytes required 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_log[i] !== {1'b0, (i == 3), exp_b[i]}) begin
          errors++;
          $display("FAIL burst_byte%0d: got %h required %h", i, out_log[i], {1'b0, (i == 3), exp_b[i]});
        end
      end
      checks++;
      if (out_cyc[3] - out_cyc[0] != 3) begin
        errors++;
        $display("FAIL burst_throughput: got span %0d cycles required 3", out_cyc[3] - out_cyc[0]);
      end
    end
  endtask

  task automatic test_alternation();
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 2; c++) begin
        src_q[c].push_back({1'b0, 8'($urandom_range(255))});
        src_q[c].push_back({1'b1, 8'($urandom_range(255))});
      end
    end
    p_valid = 100; p_ready = 100;
    run_traffic(100);
    checks++;
    if (out_log.size() != 8) begin
      errors++;
      $display("FAIL alt_len: got %0d bytes required 8", out_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_log[i][9] !== 1'((i / 2) % 2) || out_log[i][8] !== 1'(i % 2)) begin
          errors++;
          $display("FAIL alt_order%0d: got id=%b last=%b required id=%0d last=%0d",
                   i, out_log[i][9], out_log[i][8], (i / 2) % 2, i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n51 = 0;
    src_q[0] = '{{1'b0, 8'h61}, {1'b0, 8'h71}, {1'b1, 8'h72}};
    mr_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    p_valid = 100; p_ready = 100;
    run_traffic(50);
    foreach (out_log[i]) if (out_log[i][7:0] == 8'h51) n51++;
    checks++;
    if (n51 != 1 || out_log.size() != 3) begin
      errors++;
      $display("FAIL bp_transfer: got %0d x 51 in %0d bytes required 1 in 3", n51, out_log.size());
    end
    checks++;
    if (stall_cnt != 5) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d required 5", stall_cnt);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] exp_b [5] = '{8'h60, 8'h41, 8'h5A, 8'h7B, 8'hE1};
    int c0_before = cnt_model[0];
`ifdef CASE_STATS_EN
    logic [15:0] dut_before = cnt0;
`endif
    src_q[0] = '{{1'b0, 8'h60}, {1'b0, 8'h61}, {1'b0, 8'h7A}, {1'b0, 8'h7B}, {1'b1, 8'hE1}};
    p_valid = 100; p_ready = 100;
    run_traffic(50);
    checks++;
    if (out_log.size() != 5) begin
      errors++;
      $display("FAIL bound_len: got %0d bytes required 5", out_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (out_log[i][7:0] !== exp_b[i]) begin
          errors++;
          $display("FAIL bound_byte%0d: got %h required %h", i, out_log[i][7:0], exp_b[i]);
        end
      end
    end
    checks++;
    if (cnt_model[0] - c0_before != 2) begin
      errors++;
      $display("FAIL bound_model_count: got %0d required 2", cnt_model[0] - c0_before);
    end
`ifdef CASE_STATS_EN
    checks++;
    if (cnt0 - dut_before !== 16'd2) begin
      errors++;
      $display("FAIL bound_cnt0_delta: got %0d required 2", cnt0 - dut_before);
    end
`endif
  endtask

  task automatic test_random();
    int total = 0;
    for (int b = 0; b < 40; b++) begin
      int c   = int'($urandom_range(1));
      int len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        logic [7:0] d = ($urandom_range(1) == 1) ? 8'($urandom_range(8'h5B, 8'h80)) : 8'($urandom_range(255));
        src_q[c].push_back({(i == len - 1), d});
        total++;
      end
    end
    p_valid = 60; p_ready = 70;
    run_traffic(4000);
    checks++;
    if (out_log.size() != total) begin
      errors++;
      $display("FAIL rand_count: got %0d bytes required %0d", out_log.size(), total);
    end
  endtask

  task automatic test_reset_mid_burst();
    src_q[0] = '{{1'b1, 8'h61}};
    p_valid = 100; p_ready = 100;
    run_traffic(50);
    s_valid[0] = 1'b1; s_data[0] = 8'h62; s_last[0] = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got m_valid=%b required 1", m_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, m_id, m_last, s_ready} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_async: got v=%b d=%h id=%b l=%b rdy=%b required all 0",
               m_valid, m_data, m_id, m_last, s_ready);
    end
`ifdef CASE_STATS_EN
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL midrst_counters: got %0d/%0d required 0/0", cnt0, cnt1);
    end
`endif
    s_valid = 2'b11; s_last[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 2'b01) begin
      errors++;
      $display("FAIL midrst_rr_ptr: got s_ready=%b required 01", s_ready);
    end
    s_data[0] = 8'h30; s_last[0] = 1'b1; m_ready = 1'b1; s_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({m_valid, m_id, m_last, m_data} !== {1'b1, 1'b0, 1'b1, 8'h30}) begin
      errors++;
      $display("FAIL midrst_clean_byte: got v=%b id=%b l=%b d=%h required 1 0 1 30",
               m_valid, m_id, m_last, m_data);
    end
  endtask

  initial begin
    s_valid = 2'b00; s_last = 2'b00; s_data[0] = '0; s_data[1] = '0; m_ready = 1'b1;
    test_reset();
    test_single_burst();
    test_alternation();
    test_backpressure();
    test_boundaries();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
